riscv_uart_tx_mmio: RTL and testbench

//  Memory-mapped UART transmitter on the core's MEM-stage data port (dmem_addr/wdata/wen/rdata).

---
 rtl/riscv_soc_pkg.sv | 36 +++
 rtl/riscv_sync_fifo.sv | 66 ++++++
 rtl/riscv_uart_tx_mmio.sv | 180 ++++++++++++++++++
 tb/tb_riscv_uart_tx_mmio.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_soc_pkg.sv
// riscv_soc_pkg: shared SoC constants and types.
// UART MMIO addresses, status word layout, TX FSM encoding.
package riscv_soc_pkg;

    localparam logic [31:0] DEF_UART_TX_ADDR   = 32'h1000_0000;
    localparam logic [31:0] DEF_UART_STAT_ADDR = 32'h1000_0004;

    localparam int ST_FULL     = 0;
    localparam int ST_EMPTY    = 1;
    localparam int ST_BUSY     = 2;
    localparam int ST_COUNT_LO = 8;
    localparam int ST_COUNT_HI = 15;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [31:0] uart_status(
        input logic [7:0] cnt,
        input logic       busy,
        input logic       empty,
        input logic       full
    );
        logic [31:0] s;
        s = '0;
        s[ST_COUNT_HI:ST_COUNT_LO] = cnt;
        s[ST_BUSY]  = busy;
        s[ST_EMPTY] = empty;
        s[ST_FULL]  = full;
        return s;
    endfunction

endpackage

// File: rtl/riscv_sync_fifo.sv
// riscv_sync_fifo: single-clock FIFO, power-of-2 depth.
// dout shows the head entry whenever the FIFO is not empty.
module riscv_sync_fifo
    import riscv_soc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;
    logic             w_wr;
    logic             w_rd;

    assign full  = (r_cnt == CW'(DEPTH));
    assign empty = (r_cnt == '0);
    assign count = r_cnt;
    assign dout  = r_mem[r_rp];

    // Guard so a push never overwrites and a pop never underflows.
    assign w_wr = push & ~full;
    assign w_rd = pop & ~empty;

    // Storage array; contents need no reset, count gates validity.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wp] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_rd) begin
                r_rp <= r_rp + 1'b1;
            end
            if (w_wr && !w_rd) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_wr && w_rd) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/riscv_uart_tx_mmio.sv
// riscv_uart_tx_mmio: MMIO UART transmitter on the MEM-stage port.
// Decode, pipeline stall, read mux, FIFO and 8N1 serialiser.
module riscv_uart_tx_mmio
    import riscv_soc_pkg::*;
#(
    parameter int          CLKS_PER_BIT   = 868,
    parameter int          FIFO_DEPTH     = 16,
    parameter logic [31:0] UART_TX_ADDR   = DEF_UART_TX_ADDR,
    parameter logic [31:0] UART_STAT_ADDR = DEF_UART_STAT_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic        dmem_wen,
    output logic [31:0] dmem_rdata,
    output logic        uart_stall,
    output logic        ram_wen,
    input  logic [31:0] ram_rdata,
    output logic        uart_tx
);

    localparam int BAUD_W =
        (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_MAX =
        BAUD_W'(CLKS_PER_BIT - 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              w_hit_tx;
    logic              w_hit_st;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [7:0]        w_cnt8;
    logic [7:0]        w_dout;
    logic              w_busy;
    logic              w_unused;

    tx_state_e         r_state;
    tx_state_e         w_state_nxt;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baud_nxt;
    logic [2:0]        r_bit;
    logic [2:0]        w_bit_nxt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nxt;
    logic              r_tx;
    logic              w_tx_nxt;
    logic              w_baud_end;

    assign w_hit_tx = (dmem_addr == UART_TX_ADDR);
    assign w_hit_st = (dmem_addr == UART_STAT_ADDR);

    // A store to a full FIFO is held off, never pushed through.
    assign w_push     = dmem_wen & w_hit_tx & ~w_full;
    assign uart_stall = dmem_wen & w_hit_tx & w_full;
    assign ram_wen    = dmem_wen & ~w_hit_tx & ~w_hit_st;

    assign w_busy = (r_state != TX_IDLE);
    assign w_cnt8 = 8'(w_count);

    assign dmem_rdata = w_hit_st
        ? uart_status(w_cnt8, w_busy, w_empty, w_full)
        : ram_rdata;

    assign uart_tx  = r_tx;
    assign w_unused = ^dmem_wdata[31:8];

    riscv_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (dmem_wdata[7:0]),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign w_baud_end = (r_baud == BAUD_MAX);

    // TX state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: one bit period per state/bit, STOP chains to START.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            TX_IDLE: begin
                if (!w_empty) w_state_nxt = TX_START;
            end
            TX_START: begin
                if (w_baud_end) w_state_nxt = TX_DATA;
            end
            TX_DATA: begin
                if (w_baud_end && r_bit == 3'd7) begin
                    w_state_nxt = TX_STOP;
                end
            end
            TX_STOP: begin
                if (w_baud_end) begin
                    w_state_nxt = w_empty ? TX_IDLE : TX_START;
                end
            end
        endcase
    end

    // Outputs: FIFO pop, baud/bit/shift updates and next line level.
    always_comb begin
        w_pop       = 1'b0;
        w_baud_nxt  = r_baud + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        unique case (r_state)
            TX_IDLE: begin
                w_baud_nxt = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_dout;
                end
            end
            TX_START: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    w_bit_nxt  = 3'd0;
                end
            end
            TX_DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = r_bit + 3'd1;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                end
            end
            TX_STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_dout;
                    end
                end
            end
        endcase
        unique case (w_state_nxt)
            TX_IDLE:  w_tx_nxt = 1'b1;
            TX_START: w_tx_nxt = 1'b0;
            TX_DATA:  w_tx_nxt = w_shift_nxt[0];
            TX_STOP:  w_tx_nxt = 1'b1;
        endcase
    end

    // Datapath registers; line is registered so it never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

endmodule

// File: tb/tb_riscv_uart_tx_mmio.sv
// tb_riscv_uart_tx_mmio: bench for the MMIO UART transmitter.
// Vector table, directed sequences and random traffic vs a frame model.
module tb_riscv_uart_tx_mmio;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
    localparam logic [31:0] TXA = 32'h1000_0000;
    localparam logic [31:0] STA = 32'h1000_0004;
    localparam logic [31:0] RAMA = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dmem_addr = '0;
    logic [31:0] dmem_wdata = '0;
    logic        dmem_wen = 1'b0;
    logic [31:0] ram_rdata = '0;
    logic [31:0] dmem_rdata;
    logic        uart_stall;
    logic        ram_wen;
    logic        uart_tx;

    int errs = 0;
    int checks = 0;
    int cyc = 0;

    riscv_uart_tx_mmio #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_wen   (dmem_wen),
        .dmem_rdata (dmem_rdata),
        .uart_stall (uart_stall),
        .ram_wen    (ram_wen),
        .ram_rdata  (ram_rdata),
        .uart_tx    (uart_tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%h want=%h",
                     nm, cyc, act, exp);
        end
    endtask

    // Reference model: queue of waiting bytes plus a frame timer.
    logic [7:0] m_q[$];
    int         m_rem = 0;
    logic [7:0] m_cur = '0;
    bit         m_valid = 0;
    bit         m_push;
    bit         m_pop;

    function automatic logic m_tx();
        int e;
        if (m_rem == 0) return 1'b1;
        e = FRAME - m_rem;
        if (e < CPB) return 1'b0;
        if (e >= 9 * CPB) return 1'b1;
        return m_cur[e / CPB - 1];
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_q.delete();
            m_rem = 0;
            m_valid = 1;
        end else begin
            m_push = dmem_wen && dmem_addr == TXA
                     && m_q.size() < DEPTH;
            m_pop = m_q.size() > 0 && m_rem <= 1;
            if (m_pop) begin
                m_cur = m_q.pop_front();
                m_rem = FRAME;
            end else if (m_rem > 0) begin
                m_rem--;
            end
            if (m_push) m_q.push_back(dmem_wdata[7:0]);
        end
    end

    // Receiver: decodes the line and checks bytes in store order.
    logic [7:0] exp_bytes[$];
    int         starts[$];
    bit         rx_act = 0;
    int         rx_start = 0;
    logic [7:0] rx_byte = '0;

    always @(negedge clk) begin
        logic [31:0] e_rd;
        bit          e_full;
        int          off;
        if (m_valid) begin
            e_full = (m_q.size() == DEPTH);
            e_rd = ram_rdata;
            if (dmem_addr == STA)
                e_rd = 32'(m_q.size()) * 256
                     + 32'(m_rem > 0) * 4
                     + 32'(m_q.size() == 0) * 2
                     + 32'(e_full);
            chk("tx", uart_tx, m_tx());
            chk("stall", uart_stall,
                dmem_wen && dmem_addr == TXA && e_full);
            chk("ram_wen", ram_wen,
                dmem_wen && dmem_addr != TXA && dmem_addr != STA);
            chk("rdata", dmem_rdata, e_rd);
        end
        if (rst) begin
            rx_act = 0;
        end else if (!rx_act) begin
            if (uart_tx === 1'b0) begin
                rx_act = 1;
                rx_start = cyc;
                starts.push_back(cyc);
            end
        end else begin
            off = cyc - rx_start;
            if (off % CPB == 2 && off / CPB >= 1 && off / CPB <= 8)
                rx_byte[off / CPB - 1] = uart_tx;
            if (off == FRAME - 1) begin
                rx_act = 0;
                if (exp_bytes.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL rx_extra got=%h want=none",
                             rx_byte);
                end else begin
                    chk("rx_byte", rx_byte, exp_bytes.pop_front());
                end
            end
        end
    end

    task automatic step(input logic [31:0] a, input logic [31:0] wd,
                        input logic we, input logic [31:0] rr,
                        output logic st, output logic [31:0] rd,
                        output logic rw, output logic tx);
        dmem_addr = a;
        dmem_wdata = wd;
        dmem_wen = we;
        ram_rdata = rr;
        @(negedge clk);
        st = uart_stall;
        rd = dmem_rdata;
        rw = ram_wen;
        tx = uart_tx;
        @(posedge clk);
        if (we && a == TXA && !st && !rst)
            exp_bytes.push_back(wd[7:0]);
        #1;
    endtask

    logic        g_st;
    logic [31:0] g_rd;
    logic        g_rw;
    logic        g_tx;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(RAMA, '0, 1'b0, $urandom, g_st, g_rd, g_rw, g_tx);
    endtask

    task automatic store(input logic [7:0] b, output int ns);
        logic [31:0] w;
        logic        st;
        logic [31:0] rd;
        logic        rw;
        logic        tx;
        int          n;
        n = 0;
        w = $urandom;
        w[7:0] = b;
        do begin
            step(TXA, w, 1'b1, $urandom, st, rd, rw, tx);
            if (st) n++;
        end while (st && n < 300);
        if (st) begin
            checks++;
            errs++;
            $display("FAIL store_timeout byte=%h stalled=%0d", b, n);
        end
        ns = n;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wen;
        logic [31:0] rr;
        logic [31:0] exp_rd;
        logic        exp_rw;
        logic        exp_st;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #5_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          ns;
        int          s0;
        int          lows;
        logic [39:0] obs;
        logic [39:0] efr;
        logic [7:0]  b;
        logic        rwany;

        tbl[0] = '{32'h40, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0};
        tbl[1] = '{32'h40, 32'h1234_5678, 1, 32'hDEAD_BEEF,
                   32'hDEAD_BEEF, 1, 0};
        tbl[2] = '{STA, 0, 0, 32'h1111_1111, 32'h0000_0002, 0, 0};
        tbl[3] = '{STA, 32'hFF, 1, 32'h2222_2222, 32'h0000_0002, 0, 0};
        tbl[4] = '{TXA, 0, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 0};
        tbl[5] = '{32'h1000_0008, 7, 1, 32'h0BAD_F00D,
                   32'h0BAD_F00D, 1, 0};
        tbl[6] = '{32'h0FFF_FFFC, 0, 0, 32'h55AA_55AA,
                   32'h55AA_55AA, 0, 0};
        tbl[7] = '{32'h1000_0005, 9, 1, 32'h0, 32'h0, 1, 0};
        tbl[8] = '{STA, 0, 0, 32'h3333_3333, 32'h0000_0002, 0, 0};

        rst = 1'b1;
        idle(3);
        chk("reset_tx", g_tx, 1'b1);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].addr, tbl[i].wdata, tbl[i].wen, tbl[i].rr,
                 g_st, g_rd, g_rw, g_tx);
            chk($sformatf("vec%0d_rdata", i), g_rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_ram_wen", i), g_rw, tbl[i].exp_rw);
            chk($sformatf("vec%0d_stall", i), g_st, tbl[i].exp_st);
        end

        // Single byte: exact frame shape after the push edge.
        store(8'hA5, ns);
        chk("t1_stall", ns, 0);
        idle(1);
        chk("t1_pre_tx", g_tx, 1'b1);
        b = 8'hA5;
        rwany = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            idle(1);
            obs[k] = g_tx;
            rwany |= g_rw;
            if (k < CPB) efr[k] = 1'b0;
            else if (k >= 9 * CPB) efr[k] = 1'b1;
            else efr[k] = b[k / CPB - 1];
        end
        chk("t1_frame", obs, efr);
        chk("t1_ram_wen", rwany, 1'b0);
        idle(2);

        // Back-to-back stores fill the FIFO; sixth waits one frame.
        s0 = starts.size();
        for (int i = 1; i <= 5; i++) begin
            store(8'(i), ns);
            chk($sformatf("t2_stall_%0d", i), ns, 0);
        end
        store(8'h06, ns);
        chk("t2_stall_6", ns, 37);
        idle(45);
        step(STA, '0, 1'b0, $urandom, g_st, g_rd, g_rw, g_tx);
        chk("t3_status", g_rd, 32'h0000_0304);
        idle(200);
        chk("t2_frames", starts.size() - s0, 6);
        for (int i = 1; i < 6 && s0 + i < starts.size(); i++)
            chk($sformatf("t2_gap_%0d", i),
                starts[s0 + i] - starts[s0 + i - 1], FRAME);
        chk("t2_drain", exp_bytes.size(), 0);

        // Reset during DATA bit 3 with two bytes waiting.
        store(8'h3C, ns);
        store(8'h5A, ns);
        store(8'hC3, ns);
        idle(15);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_bytes.delete();
        s0 = starts.size();
        step(STA, '0, 1'b0, $urandom, g_st, g_rd, g_rw, g_tx);
        chk("t5_tx", g_tx, 1'b1);
        chk("t5_status", g_rd, 32'h0000_0002);
        lows = 0;
        for (int k = 0; k < 100; k++) begin
            idle(1);
            if (g_tx !== 1'b1) lows++;
        end
        chk("t5_quiet", lows, 0);
        chk("t5_frames", starts.size() - s0, 0);

        // Store landing while in STOP with nothing queued.
        s0 = starts.size();
        store(8'h81, ns);
        idle(37);
        store(8'h7E, ns);
        chk("t6_stall", ns, 0);
        idle(60);
        chk("t6_frames", starts.size() - s0, 2);
        if (starts.size() - s0 >= 2)
            chk("t6_gap", starts[s0 + 1] - starts[s0], FRAME);

        // Random mix of UART and RAM traffic.
        for (int i = 0; i < 300; i++) begin
            int r;
            logic [31:0] ad;
            r = $urandom_range(0, 9);
            ad = $urandom;
            ad = ad & 32'h0FFF_FFFC;
            if (r <= 3) begin
                store(8'($urandom), ns);
            end else if (r <= 5) begin
                step(STA, $urandom, 1'($urandom), $urandom,
                     g_st, g_rd, g_rw, g_tx);
            end else if (r <= 7) begin
                step(ad, $urandom, 1'($urandom), $urandom,
                     g_st, g_rd, g_rw, g_tx);
            end else if (r == 8) begin
                step(TXA, $urandom, 1'b0, $urandom,
                     g_st, g_rd, g_rw, g_tx);
            end else begin
                idle(1);
            end
        end
        idle(FRAME * (DEPTH + 2));
        chk("rand_drain", exp_bytes.size(), 0);
        step(STA, '0, 1'b0, $urandom, g_st, g_rd, g_rw, g_tx);
        chk("final_status", g_rd, 32'h0000_0002);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
